// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read address/data channel bundle
//
// Carries one AXI4 read port (AR + R channels).
//   master modport: the side that issues AR and accepts R beats
//   slave modport : the side that accepts AR and returns R beats
// Signals: arvalid/arready, araddr, arid, arlen, arsize, arburst,
//          rvalid/rready, rdata, rresp, rlast, rid
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin arbiter for one AXI4 read port
//
// Shares the SRAM read port between the IFU (m0) and the LSU (m1), one
// transaction in flight at a time; the grant is held until the burst's
// last beat is accepted.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   m0, m1       : read ports facing IFU / LSU (arbiter is their slave)
//   s            : read port facing the memory (arbiter is its master)
//   grant        : one-hot owner, bit0 = m0, bit1 = m1, 00 = none
//   busy         : a transaction is in its address or data phase
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  axi_rd_arbiter_if.slave   m0,
  axi_rd_arbiter_if.slave   m1,
  axi_rd_arbiter_if.master  s,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  // 1 when m1 owned the most recent transaction; resets to 1 so m0 wins
  // the first tie.
  logic       last_grant_q, last_grant_d;
  logic       win_m1;

  // Selected master's request-side signals.
  logic                  sel_m1;
  logic                  sel_arvalid;
  logic                  sel_rready;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [ID_WIDTH-1:0]   sel_arid;
  logic [7:0]            sel_arlen;
  logic [2:0]            sel_arsize;
  logic [1:0]            sel_arburst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign sel_m1 = grant_q[1];

  always_comb begin
    sel_arvalid = sel_m1 ? m1.arvalid : m0.arvalid;
    sel_rready  = sel_m1 ? m1.rready  : m0.rready;
    sel_araddr  = sel_m1 ? m1.araddr  : m0.araddr;
    sel_arid    = sel_m1 ? m1.arid    : m0.arid;
    sel_arlen   = sel_m1 ? m1.arlen   : m0.arlen;
    sel_arsize  = sel_m1 ? m1.arsize  : m0.arsize;
    sel_arburst = sel_m1 ? m1.arburst : m0.arburst;
  end

  // Next-state, grant and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    win_m1       = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (m0.arvalid || m1.arvalid) begin
          // On a tie the master that did not own the last burst goes next.
          win_m1       = (m0.arvalid && m1.arvalid) ? ~last_grant_q : m1.arvalid;
          grant_d      = win_m1 ? 2'b10 : 2'b01;
          last_grant_d = win_m1;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        // A master that withdraws arvalid simply keeps the arbiter here.
        if (sel_arvalid && s.arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (s.rvalid && sel_rready && s.rlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Channel steering. Everything not explicitly routed is held at zero, so
  // the idle master and every phase we are not in see a quiet bus.
  always_comb begin
    s.arvalid  = 1'b0;
    s.araddr   = '0;
    s.arid     = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.rid     = '0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.rid     = '0;
    case (state_q)
      ADDR: begin
        s.arvalid  = sel_arvalid;
        s.araddr   = sel_araddr;
        s.arid     = sel_arid;
        s.arlen    = sel_arlen;
        s.arsize   = sel_arsize;
        s.arburst  = sel_arburst;
        m0.arready = ~sel_m1 & s.arready;
        m1.arready =  sel_m1 & s.arready;
      end
      DATA: begin
        s.rready = sel_rready;
        if (sel_m1) begin
          m1.rvalid = s.rvalid;
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
          m1.rlast  = s.rlast;
          m1.rid    = s.rid;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
          m0.rlast  = s.rlast;
          m0.rid    = s.rid;
        end
      end
      default: begin
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule
